clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
Run-time controller for a 50%-duty integer clock divider, generalising the fixed divide-by-5 pos/neg-edge scheme to any divisor from 2 to 2^WIDTH-1.
- Accepts new divisors over a valid/ready handshake.
- Applies each change only at a period boundary, so clk_out never glitches or shortens a pulse.
- Starts and stops the divided clock cleanly on en.
- Sits between the control logic and every consumer of a derived slow clock.

Parameters:
WIDTH, 8, width of divisor and phase counter
DEFAULT_DIV, 5, divisor loaded at reset (must be >= 2)

Ports:
clk_in  in  1  input clock; the only clock (posedge logic, plus one negedge flop when the optional feature is on)
rst  in  1  reset, asynchronous, active-high; clears all state immediately
en  in  1  run request; 1 = produce divided clock
cfg_valid  in  1  new divisor offered
cfg_div  in  WIDTH  offered divisor
cfg_ready  out  1  divisor can be accepted this cycle
cfg_err  out  1  one-cycle pulse: offered divisor < 2, rejected
clk_out  out  1  divided clock
running  out  1  divider is in RUN or STOP
period_tick  out  1  one-cycle pulse on the posedge where a new period starts (cnt becomes 0)

Behaviour:
Reset values:
- div_q = DEFAULT_DIV; pend_q, pend_v, cnt, pos_q, neg_q, period_tick, cfg_err = 0.
- clk_out = 0, running = 0, cfg_ready = 1; state = IDLE.

Counter and waveform:
- cnt runs 0..div_q-1, then wraps to 0.
- H = div_q >> 1.
- pos_q registered on posedge: pos_q <= (cnt_next < H) && state_next != IDLE.
- neg_q samples pos_q on the negedge of clk_in.
- clk_out = pos_q | (neg_q & div_q[0]).
- Result: high for exactly div_q/2 input periods, including the half period for odd divisors.
- Example, N=5: pos_q high for cnt 0,1; clk_out high 2.5 periods, low 2.5 periods.

States:
- IDLE: cnt = 0, clk_out = 0. On en=1, next posedge goes to RUN with cnt = 0 and period_tick = 1. First clk_out rise is 1 cycle after en is sampled.
- RUN: counts.
  - At cnt == div_q-1 with en=1: wrap; period_tick = 1; if pend_v, then div_q <= pend_q and pend_v <= 0 in the same edge.
  - If en=0 at any point in RUN: go to STOP.
- STOP: keep counting to cnt == div_q-1, then go to IDLE. Any pending divisor is loaded on that edge. No truncated pulse.
  - en reasserted during STOP: return to RUN and continue the current period without restarting.

Handshake:
- cfg_ready = ~pend_v.
- Transfer happens when cfg_valid & cfg_ready at a posedge.
- cfg_div >= 2: captured into pend_q, pend_v <= 1.
- cfg_div < 2: cfg_err pulses for 1 cycle; nothing captured; cfg_ready stays 1.
- In IDLE, a pending divisor loads on the next posedge (1-cycle latency).
- In RUN/STOP, it loads at the next period boundary.
- Transfer on the same edge as a boundary: takes effect at the following boundary, not the current one.

Other rules:
- running = (state != IDLE).
- period_tick is registered and aligned with cnt == 0.
- Reset mid-operation: clk_out falls asynchronously with rst. No pending divisor survives reset.

Optional Feature:
CLK_DIV_SCHED_DUTY50_EN
- Defined: negedge flop neg_q is present; odd divisors produce exact 50% duty as above.
- Undefined: no negedge logic; clk_out = pos_q only. Odd divisors are high floor(N/2) of N cycles (N=5: high 2, low 3). Even divisors are unchanged.
- Handshake, states and period_tick are identical in both builds.

Test Plan:
- Reset, en=1, default N=5 -> clk_out period 5 input clocks; high from posedge to the negedge 2.5 clocks later; period_tick every 5 clocks; running=1.
- cfg_div=4 while in IDLE, then en=1 -> div loads in 1 cycle; clk_out high 2 / low 2; cfg_ready back to 1 after load.
- Running N=5, cfg_div=3 accepted at cnt=1 -> cfg_ready=0 until the wrap after cnt=4. Current period completes as N=5; the next period is 3 clocks, high 1.5. A second cfg_valid during the wait is not accepted.
- cfg_div=1 (and 0) while running -> cfg_err pulses 1 cycle; divisor unchanged; clk_out undisturbed.
- en=0 at cnt=1 of N=6 -> output completes the period (high cnt 0..2, low 3..5), then IDLE with clk_out=0 and running=0. With en re-raised at cnt=3 instead, no gap appears.
- rst asserted asynchronously while clk_out=1, mid-period -> clk_out=0 and running=0 without a clock edge; after release, div=DEFAULT_DIV and pending config is cleared.

Source files
------------

// File: rtl/clk_div_sched_if.sv
// Divisor configuration channel for clk_div_sched.
// The master offers a divisor (cfg_valid/cfg_div) and the divider answers
// with cfg_ready and a one-cycle cfg_err pulse for rejected values.
interface clk_div_sched_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_sched.sv
// clk_div_sched: run-time controlled integer clock divider (divisor 2..2^WIDTH-1).
// New divisors arrive over a valid/ready channel and are applied only at a
// period boundary; en starts and stops the output on whole periods.
// Optional build macro CLK_DIV_SCHED_DUTY50_EN adds a negedge flop so odd
// divisors get an exact 50% duty cycle; without it clk_out = pos_q only.
module clk_div_sched #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    clk_div_sched_if.slave       cfg,
    output logic                 clk_out,
    output logic                 running,
    output logic                 period_tick
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q;
    logic             pend_v_q;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;
    logic             err_q;
    logic             running_q;
    logic             boundary;
    logic             load;
    logic             accept;
    logic             bad_div;

    // Next-state of the period counter / FSM; the high phase uses the divisor
    // that will be in force after this edge so a reload shapes its first period.
    always_comb begin
        boundary = (cnt_q == (div_q - 1'b1));
        accept   = cfg.cfg_valid & ~pend_v_q;
        bad_div  = (cfg.cfg_div < WIDTH'(2));
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        load     = 1'b0;
        tick_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                load  = pend_v_q;
                if (en) begin
                    state_d = RUN;
                    tick_d  = 1'b1;
                end
            end
            RUN, STOP: begin
                if (boundary) begin
                    cnt_d = '0;
                    load  = pend_v_q;
                    if (en) begin
                        state_d = RUN;
                        tick_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = en ? RUN : STOP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (load) begin
            div_d = pend_q;
        end
        pos_d = (state_d != IDLE) && (cnt_d < (div_d >> 1));
    end

    // FSM, counter, divisor/pending registers and all registered outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= WIDTH'(DEFAULT_DIV);
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            pos_q     <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pos_q     <= pos_d;
            tick_q    <= tick_d;
            running_q <= (state_d != IDLE);
            err_q     <= accept & bad_div;
            // A load clears the slot; a transfer can only happen while empty.
            if (load) begin
                pend_v_q <= 1'b0;
            end
            if (accept && !bad_div) begin
                pend_q   <= cfg.cfg_div;
                pend_v_q <= 1'b1;
            end
        end
    end

    assign cfg.cfg_ready = ~pend_v_q;
    assign cfg.cfg_err   = err_q;
    assign running       = running_q;
    assign period_tick   = tick_q;

`ifdef CLK_DIV_SCHED_DUTY50_EN
    logic neg_q;

    // Half-cycle delayed copy of pos_q that stretches odd-divisor pulses.
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign clk_out = pos_q | (neg_q & div_q[0]);
`else
    assign clk_out = pos_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: a period-level reference model pushes
// the expected per-cycle response; monitors pop and compare on both edges.
module tb_clk_div_sched;
    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 5;
`ifdef CLK_DIV_SCHED_DUTY50_EN
    localparam bit DUTY50 = 1'b1;
`else
    localparam bit DUTY50 = 1'b0;
`endif

    typedef struct packed {
        logic tick;
        logic run;
        logic ready;
        logic err;
        logic hi_p;
        logic hi_n;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic en     = 1'b0;
    logic clk_out, running, period_tick;

    clk_div_sched_if #(.WIDTH(WIDTH)) cfg_if ();

    clk_div_sched #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .cfg        (cfg_if),
        .clk_out    (clk_out),
        .running    (running),
        .period_tick(period_tick)
    );

    always #5 clk_in = ~clk_in;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic neg_exp = 1'b0;
    logic neg_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    // Reference model: tracks whole periods (cycles remaining in the current
    // period, the divisor that period was started with) and a one-deep
    // pending slot; a period boundary is when the last cycle is consumed.
    int m_div  = DEFAULT_DIV;
    int m_pend = 0;
    bit m_pv   = 1'b0;
    int m_rem  = 0;
    int m_pdiv = DEFAULT_DIV;

    always @(posedge clk_in) begin
        exp_t e;
        bit   acc, err;
        int   cnt, limit;
        e = '0;
        if (rst) begin
            m_div = DEFAULT_DIV;
            m_pv  = 1'b0;
            m_rem = 0;
            e.ready = 1'b1;
        end else begin
            acc = cfg_if.cfg_valid && !m_pv;
            err = acc && (cfg_if.cfg_div < 2);
            if (m_rem <= 1) begin
                if (m_pv) begin
                    m_div = m_pend;
                    m_pv  = 1'b0;
                end
                if (en) begin
                    m_rem  = m_div;
                    m_pdiv = m_div;
                    e.tick = 1'b1;
                end else begin
                    m_rem = 0;
                end
            end else begin
                m_rem--;
            end
            if (acc && !err) begin
                m_pend = int'(cfg_if.cfg_div);
                m_pv   = 1'b1;
            end
            cnt     = m_pdiv - m_rem;
            limit   = DUTY50 ? m_pdiv : 2 * (m_pdiv / 2);
            e.run   = (m_rem > 0);
            e.ready = !m_pv;
            e.err   = err;
            e.hi_p  = (m_rem > 0) && (2 * cnt < limit);
            e.hi_n  = (m_rem > 0) && (2 * cnt + 1 < limit);
        end
        exp_q.push_back(e);
    end

    // Posedge monitor: pops one expected response per edge.
    always @(posedge clk_in) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty at %0t: actual=0 required=1", $time);
            neg_vld = 1'b0;
        end else begin
            e = exp_q.pop_front();
            chk("period_tick", 32'(period_tick), 32'(e.tick));
            chk("running", 32'(running), 32'(e.run));
            chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(e.ready));
            chk("cfg_err", 32'(cfg_if.cfg_err), 32'(e.err));
            chk("clk_out_pos", 32'(clk_out), 32'(e.hi_p));
            neg_exp = e.hi_n;
            neg_vld = 1'b1;
        end
    end

    // Negedge monitor: checks the second half of each input period.
    always @(negedge clk_in) begin
        #1;
        if (neg_vld) chk("clk_out_neg", 32'(clk_out), 32'(neg_exp));
    end

    task automatic step(input logic e, input logic v, input logic [WIDTH-1:0] d);
        en               = e;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_div   = d;
        @(posedge clk_in);
        #2;
    endtask

    task automatic steps(input int n, input logic e);
        for (int k = 0; k < n; k++) step(e, 1'b0, '0);
    endtask

    initial begin
        logic        e_r;
        logic        v;
        int          r;
        int          d;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        #1;
        chk("reset_clk_out", 32'(clk_out), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("reset_period_tick", 32'(period_tick), 32'd0);
        chk("reset_cfg_err", 32'(cfg_if.cfg_err), 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        rst = 1'b0;

        // Default divisor running, then stop.
        steps(12, 1'b1);
        steps(8, 1'b0);
        // Divisor 4 loaded while idle, then run.
        step(1'b0, 1'b1, 8'd4);
        step(1'b0, 1'b0, 8'd0);
        steps(9, 1'b1);
        // Back to 5, then offer 3 mid-period plus a second offer while waiting.
        step(1'b1, 1'b1, 8'd5);
        steps(5, 1'b1);
        step(1'b1, 1'b1, 8'd3);
        step(1'b1, 1'b1, 8'd7);
        steps(12, 1'b1);
        // Illegal divisors while running.
        step(1'b1, 1'b1, 8'd1);
        step(1'b1, 1'b1, 8'd0);
        steps(4, 1'b1);
        // Divisor 6: stop mid-period, then a re-raise inside STOP.
        step(1'b1, 1'b1, 8'd6);
        steps(8, 1'b1);
        steps(10, 1'b0);
        steps(2, 1'b1);
        steps(2, 1'b0);
        steps(10, 1'b1);
        // Extremes of the divisor range.
        step(1'b1, 1'b1, 8'd2);
        steps(8, 1'b1);
        step(1'b1, 1'b1, 8'd255);
        steps(520, 1'b1);
        step(1'b1, 1'b1, 8'd3);
        steps(270, 1'b0);

        // Randomized traffic.
        e_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) e_r = ~e_r;
            v = ($urandom_range(3) == 0);
            r = int'($urandom_range(9));
            if (r < 2) d = r;
            else if (r < 8) d = int'($urandom_range(2, 9));
            else d = int'($urandom_range(10, 20));
            step(e_r, v, WIDTH'(d));
        end

        // Asynchronous reset while clk_out is high with a divisor pending.
        steps(24, 1'b0);
        step(1'b0, 1'b1, 8'd7);
        steps(2, 1'b0);
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b1, 8'd9);
        cfg_if.cfg_valid = 1'b0;
        @(negedge clk_in);
        #2;
        chk("pre_reset_clk_out", 32'(clk_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_clk_out", 32'(clk_out), 32'd0);
        chk("async_reset_running", 32'(running), 32'd0);
        chk("async_reset_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
        @(posedge clk_in);
        #2;
        rst = 1'b0;
        // After release: default divisor, nothing pending.
        steps(14, 1'b1);
        steps(8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
